regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised register bank for the pipelined core, successor to the fixed 32x32 bank.
//  Width and depth are configurable; register 0 can be hardwired to zero.
//  An optional write-to-read bypass lets a writeback result reach decode in the same cycle.
//  A clear sequencer zeroes the whole bank on request, one register per cycle.
// PARAMETERS
//  DATA_WIDTH  32  width of each register / data port
//  ADDR_WIDTH  5   address width; DEPTH = 2**ADDR_WIDTH registers
//  ZERO_REG    1   1: reg 0 reads as 0 and ignores writes; 0: reg 0 is ordinary storage
//  BYPASS      1   1: same-cycle write data forwarded to matching read port; 0: reads show stored value only
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  rst        in   1           asynchronous, active-high reset
//  we         in   1           write enable (writeback stage)
//  wa         in   ADDR_WIDTH  write address
//  wd         in   DATA_WIDTH  write data
//  ra1        in   ADDR_WIDTH  read address, port 1
//  ra2        in   ADDR_WIDTH  read address, port 2
//  rd1        out  DATA_WIDTH  read data, port 1 (combinational)
//  rd2        out  DATA_WIDTH  read data, port 2 (combinational)
//  clr_req    in   1           single-cycle pulse; starts bank clear
//  clr_busy   out  1           high while clear sequence runs
// BEHAVIOUR
//  Reset (async, rst=1): all DEPTH registers <= 0, FSM <= IDLE, clear index <= 0, clr_busy=0.
//   rd1/rd2 therefore read 0 during and after reset until written.
//  Write: at rising clk when we=1 and FSM=IDLE -> mem[wa] <= wd. Latency 1 edge.
//   ZERO_REG=1 and wa=0: write dropped, no state change.
//  Read (both ports identical, independent, 0-cycle latency), priority high to low:
//   1. ZERO_REG=1 and ra=0                            -> 0
//   2. BYPASS=1, FSM=IDLE, we=1, wa=ra (and not rule 1) -> wd
//   3. otherwise                                      -> mem[ra]
//   Both ports may address the same register; both return the same value.
//  Clear FSM, states IDLE, CLEAR:
//   IDLE : clr_req=1 at edge -> CLEAR, idx <= 0. A we=1 on that same edge is still accepted.
//   CLEAR: each edge mem[idx] <= 0, idx <= idx+1; after idx=DEPTH-1 is cleared -> IDLE.
//    Duration exactly DEPTH cycles; clr_busy=1 in every CLEAR cycle (registered, = FSM==CLEAR).
//    we ignored (writes dropped, no queuing); bypass disabled; reads return mem as it
//    stands (registers below idx already 0, others old contents).
//    clr_req while CLEAR: ignored, sequence is not restarted or extended.
//   idx counter is ADDR_WIDTH bits; terminal condition compares to DEPTH-1, no wrap past it.
//  Reset mid-CLEAR: immediate return to IDLE with all registers 0, clr_busy=0.
//  No X propagation: every mem entry has a defined reset value.
// TESTING
//  1. rst pulse, then ra1=1, ra2=31 -> rd1=0, rd2=0, clr_busy=0.
//  2. we=1 wa=1 wd=DEADBEEF one edge, then wa=2 CAFEBABE, wa=31 12345678; we=0; ra1=1,ra2=2
//     -> rd1=DEADBEEF, rd2=CAFEBABE; ra1=31 -> 12345678.
//  3. Bypass: we=1 wa=5 wd=A5A5A5A5, ra1=5 ra2=5 before edge -> rd1=rd2=A5A5A5A5 same cycle;
//     BYPASS=0 build -> old mem[5] until after edge.
//  4. Zero reg: we=1 wa=0 wd=FFFFFFFF, ra1=0 -> rd1=0 before and after edge (ZERO_REG=1);
//     ZERO_REG=0 build -> rd1=FFFFFFFF after edge.
//  5. Clear: fill regs 1..31 with index value, pulse clr_req -> clr_busy high exactly 32 cycles;
//     we=1 wa=3 wd=77 mid-clear dropped; second clr_req ignored; afterwards all reads 0.
//  6. Reset mid-clear: clr_req, assert rst after 10 cycles -> clr_busy=0 immediately, all regs 0,
//     next write wa=4 wd=11 accepted on first edge after rst release.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register bank with optional zero register, write-to-read bypass
// and a one-register-per-cycle clear sequencer.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   idx_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_ok;

    // Writes are only honoured in IDLE; the zero register silently swallows its writes.
    assign wr_ok = (state == IDLE) && we && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_sel(input logic [ADDR_WIDTH-1:0] ra);
        logic [DATA_WIDTH-1:0] val;
        if ((ZERO_REG != 0) && (ra == '0)) begin
            val = '0;
        end else if ((BYPASS != 0) && (state == IDLE) && we && (wa == ra)) begin
            val = wd;
        end else begin
            val = mem[ra];
        end
        return val;
    endfunction

    assign rd1      = read_sel(ra1);
    assign rd2      = read_sel(ra2);
    assign clr_busy = (state == CLEAR);

endmodule
